// File: rtl/wb_slave_core.sv
// Wishbone B4 pipelined slave over a word-addressed register array.
// One single-beat request per clock, byte-lane writes, registered ack/err one cycle later.
module wb_slave_core #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  we_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so the full address compares against MEM_DEPTH without wrap.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic                  accept;
    logic                  addr_bad;
    logic                  req_err;
    logic                  wr_en;
    logic                  rd_en;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] wr_word;

    assign stall_o  = 1'b0;
    assign accept   = cyc_i && stb_i && !stall_o;
    assign addr_bad = ({1'b0, adr_i} >= DEPTH_L);
    assign req_err  = addr_bad || (sel_i == '0);
    assign wr_en    = accept && !req_err && we_i;
    assign rd_en    = accept && !req_err && !we_i;
    assign idx      = adr_i[IDX_W-1:0];
    assign cur_word = mem_q[idx];

    always_comb begin
        wr_word = cur_word;
        for (int b = 0; b < SEL_WIDTH; b++) begin
            if (sel_i[b]) begin
                wr_word[8*b +: 8] = dat_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        ack_d = accept && !req_err;
        err_d = accept && req_err;
        dat_d = rd_en ? cur_word : dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
        end
    end

    // Reset clears the whole array, so storage is flops rather than a RAM macro.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_wb_slave_core.sv
// Directed vector bench for wb_slave_core: one request per vector, response checked after the edge.
module tb_wb_slave_core;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    wb_slave_core #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .SEL_WIDTH (4),
        .MEM_DEPTH (256)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .sel_i  (sel_i),
        .we_i   (we_i),
        .stb_i  (stb_i),
        .cyc_i  (cyc_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .stall_o(stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic cyc, logic stb, logic we, logic [15:0] adr,
                                logic [31:0] dat, logic [3:0] sel, logic ea, logic ee,
                                logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr;
        v.dat = dat; v.sel = sel; v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic cyc, logic stb, logic we, logic [15:0] adr,
                         logic [31:0] dat, logic [3:0] sel);
        rst_i = rst; cyc_i = cyc; stb_i = stb; we_i = we;
        adr_i = adr; dat_i = dat; sel_i = sel;
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 ns later.
    task automatic step(logic rst, logic cyc, logic stb, logic we, logic [15:0] adr,
                        logic [31:0] dat, logic [3:0] sel);
        @(negedge clk_i);
        drive(rst, cyc, stb, we, adr, dat, sel);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_resp(string tag, logic ea, logic ee, logic [31:0] ed);
        check($sformatf("%s ack", tag), {31'b0, ack_o}, {31'b0, ea});
        check($sformatf("%s err", tag), {31'b0, err_o}, {31'b0, ee});
        check($sformatf("%s stall", tag), {31'b0, stall_o}, 32'h0);
        check($sformatf("%s dat", tag), dat_o, ed);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        //            rst   cyc   stb   we    adr       dat           sel    ack   err   dat_o
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 32'h0,        4'hF, 1'b1, 1'b0, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0,        4'h1, 1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 32'h0,        4'hF, 1'b1, 1'b0, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 32'h55555555, 4'hF, 1'b0, 1'b1, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 32'h0,        4'hF, 1'b1, 1'b0, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 32'h0,        4'hF, 1'b0, 1'b0, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 32'h0,        4'hF, 1'b0, 1'b1, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h00FF, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 32'h11BB33DD));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF, 32'h0,        4'hF, 1'b1, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        4'hF, 1'b0, 1'b0, 32'hA5A5A5A5));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].adr,
                 vecs[i].dat, vecs[i].sel);
            check_resp($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_dat);
        end

        // Burst of 8 writes then 8 reads with no idle cycles in between.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 16'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF);
            check_resp($sformatf("burst_wr%0d", i), 1'b1, 1'b0, 32'hA5A5A5A5);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 16'(i), 32'h0, 4'hF);
            check_resp($sformatf("burst_rd%0d", i), 1'b1, 1'b0,
                       32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end

        // Read-after-write to the same address on the very next cycle.
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 32'hCAFEF00D, 4'hF);
        check_resp("raw_wr", 1'b1, 1'b0, 32'h1707_0707);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
        check_resp("raw_rd", 1'b1, 1'b0, 32'hCAFEF00D);

        // cyc dropped in the response cycle: the registered ack still pulses once.
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF);
        check_resp("cyc_drop_acc", 1'b1, 1'b0, 32'h1202_0202);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 32'h0, 4'hF);
        check_resp("cyc_drop_next", 1'b0, 1'b0, 32'h1202_0202);

        // Reset in the cycle after an accepted read drops the response and clears data.
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        check_resp("pre_rst_rd", 1'b1, 1'b0, 32'hDEADBEEF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 4'hF);
        check_resp("in_rst", 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 4'hF);
        check_resp("post_rst_idle", 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        check_resp("post_rst_rd10", 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF, 32'h0, 4'hF);
        check_resp("post_rst_rdFF", 1'b1, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
